// File: rtl/router_pkg.sv
// Purpose: shared router types - drain FSM states, header length-field defaults, length extraction helper.
// Latency: none; declarations and a combinational helper only.
// Backpressure: not applicable.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GET  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } drain_state_t;

    localparam int DRAIN_LEN_LSB = 0;
    localparam int DRAIN_LEN_W   = 8;

    // Widest header word the length helper accepts; callers zero-extend into it.
    localparam int HDR_MAX_W = 64;

    // Pull the payload-length field out of a header word; all other bits are ignored.
    function automatic logic [HDR_MAX_W-1:0] hdr_len(input logic [HDR_MAX_W-1:0] word,
                                                     input int lsb,
                                                     input int w);
        logic [HDR_MAX_W-1:0] mask;
        mask = (w >= HDR_MAX_W) ? '1 : ((HDR_MAX_W'(1) << w) - HDR_MAX_W'(1));
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Purpose: router FIFO bus; writer pushes with put/data_in, reader pops with an edge-triggered get.
// Latency: FIFO updates data_out/empty at the posedge ending a get-high cycle.
// Backpressure: writer watches full, reader watches empty.
interface fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  put;
    logic                  get;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    // Read-side master (drain)
    modport DST (output get, put, data_in, input empty, full, data_out);

    // The FIFO itself
    modport FIFO (input put, get, data_in, output full, empty, data_out);
endinterface

// File: rtl/fifo_drain.sv
// Purpose: pops router FIFO words with single-cycle get pulses and frames them into sop/eop packets (stall timeout: FIFO_DRAIN_TIMEOUT_EN).
// Latency: get pulse to out_valid 2 cycles; 3 cycles per word with the FIFO non-empty and out_ready high.
// Backpressure: out_ready low holds the word stable in SEND and issues no further gets.
module fifo_drain
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LEN_LSB     = DRAIN_LEN_LSB,
    parameter int LEN_W       = DRAIN_LEN_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_if.DST                   fifo_bus,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic                  err
);

    drain_state_t     state;
    drain_state_t     state_nxt;
    logic             in_pkt;
    logic [LEN_W-1:0] len_cnt;
    logic [LEN_W-1:0] hdr_len_w;
    logic             unused_full;
    logic             tmo_hit;

    // get is high only in GET; CAPT always follows, so the FIFO sees a fresh rising edge per pop.
    assign fifo_bus.get     = (state == GET);
    assign fifo_bus.put     = 1'b0;
    assign fifo_bus.data_in = '0;
    assign unused_full      = fifo_bus.full;

    assign out_valid = (state == SEND);
    // The header is already popped while in CAPT, so busy covers that cycle too.
    assign busy      = in_pkt | (state == CAPT);
    assign hdr_len_w = LEN_W'(hdr_len(HDR_MAX_W'(fifo_bus.data_out), LEN_LSB, LEN_W));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: pop, capture, present, then pop again or idle depending on empty
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_bus.empty) state_nxt = GET;
            GET:     state_nxt = CAPT;
            CAPT:    state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = fifo_bus.empty ? IDLE : GET;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall;
    logic               err_q;

    // A stall is a cycle spent waiting mid-packet on an empty FIFO; any pop leaves IDLE and clears it.
    assign stall   = in_pkt && (state == IDLE) && fifo_bus.empty;
    assign tmo_hit = stall && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Consecutive-stall counter and one-cycle timeout pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (tmo_hit || !stall) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end

    assign err = err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // Capture and framing: the first word after an idle packet boundary is a header, the rest payload
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data <= '0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            len_cnt  <= '0;
            in_pkt   <= 1'b0;
        end else if (state == CAPT) begin
            out_data <= fifo_bus.data_out;
            if (!in_pkt) begin
                out_sop <= 1'b1;
                out_eop <= (hdr_len_w == '0);
                len_cnt <= hdr_len_w;
                in_pkt  <= 1'b1;
            end else begin
                out_sop <= 1'b0;
                out_eop <= (len_cnt == LEN_W'(1));
                if (len_cnt != '0) begin
                    len_cnt <= len_cnt - LEN_W'(1);
                end
            end
        end else if (out_valid && out_ready && out_eop) begin
            in_pkt <= 1'b0;
        end else if (tmo_hit) begin
            // Abandon the stalled packet; the next popped word starts a new one.
            in_pkt  <= 1'b0;
            len_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Purpose: directed bench for fifo_drain with a behavioural edge-triggered FIFO and a beat table.
// Latency: FIFO model pops at the posedge ending a get-high cycle, matching the router FIFO.
// Backpressure: out_ready is driven by the directed sequences.
module tb_fifo_drain;
    import router_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct {
        logic [DW-1:0] word;
        logic          sop;
        logic          eop;
    } vec_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          busy;
    logic          err;

    fifo_if #(.DATA_WIDTH(DW)) bus ();

    fifo_drain #(
        .DATA_WIDTH (DW),
        .LEN_LSB    (0),
        .LEN_W      (8),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_bus (bus),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: pops on a rising edge of get seen through a 1-cycle delay register
    logic [DW-1:0] q[$];
    logic [DW-1:0] f_dout  = '0;
    logic          f_empty = 1'b1;
    logic          get_d   = 1'b0;
    int            pop_count = 0;

    assign bus.data_out = f_dout;
    assign bus.empty    = f_empty;
    assign bus.full     = 1'b0;

    always @(posedge clk) begin
        if (bus.get && !get_d && q.size() > 0) begin
            f_dout    <= q.pop_front();
            pop_count <= pop_count + 1;
        end
        get_d   <= rst ? bus.get : 1'b0;
        f_empty <= (q.size() == 0);
    end

    // Monitor: sample late in the low phase, after inputs are driven and before the next posedge
    int   cyc = 0;
    vec_t beats[$];
    vec_t mon_b;
    int   get_cyc[$];
    int   busy_samples = 0;
    int   err_count    = 0;
    int   stall_run    = 0;
    int   stall_at_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            if (out_valid && out_ready) begin
                mon_b.word = out_data;
                mon_b.sop  = out_sop;
                mon_b.eop  = out_eop;
                beats.push_back(mon_b);
            end
            if (bus.get) get_cyc.push_back(cyc);
            if (busy) busy_samples++;
            if (err) begin
                err_count++;
                stall_at_err = stall_run;
            end
            if (bus.get || out_valid) stall_run = 0;
            else if (busy && f_empty) stall_run++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            @(negedge clk);
            #4;
            k++;
        end
        chk("beat_count_wait", 32'(beats.size()), 32'(n));
    endtask

    vec_t tbl[16];

    task automatic push(input int i);
        q.push_back(tbl[i].word);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  n_beats;
        int  g0;
        int  b0;
        int  d0;
        int  p0;
        int  g1;
        int  e0;
        int  k;
        logic found;

        // word, expected sop, expected eop -- each pushed word yields exactly one beat
        tbl[0]  = '{32'h0000_0002, 1'b1, 1'b0};   // pkt len 2
        tbl[1]  = '{32'h0000_00A1, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_00A2, 1'b0, 1'b1};
        tbl[3]  = '{32'h0000_0000, 1'b1, 1'b1};   // zero-length
        tbl[4]  = '{32'hABCD_0001, 1'b1, 1'b0};   // upper bits ignored, len 1
        tbl[5]  = '{32'h0000_0055, 1'b0, 1'b1};
        tbl[6]  = '{32'h0000_0002, 1'b1, 1'b0};   // backpressure packet
        tbl[7]  = '{32'h0000_00A1, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_00A2, 1'b0, 1'b1};
        tbl[9]  = '{32'h0000_0003, 1'b1, 1'b0};   // underflow packet
        tbl[10] = '{32'h0000_00B1, 1'b0, 1'b0};
        tbl[11] = '{32'h0000_00B2, 1'b0, 1'b0};
        tbl[12] = '{32'h0000_00B3, 1'b0, 1'b1};
        tbl[13] = '{32'h0000_0003, 1'b1, 1'b0};   // abandoned by timeout
        tbl[14] = '{32'h0000_00C1, 1'b0, 1'b0};
        tbl[15] = '{32'h0000_0100, 1'b1, 1'b1};   // fresh header after timeout, len 0

        // Reset with data queued: nothing popped, outputs quiet
        push(0); push(1); push(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            chk("rst_get", 32'(bus.get), 32'd0);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_data", out_data, 32'd0);
        chk("rst_depth", 32'(q.size()), 32'd3);
        chk("rst_pops", 32'(pop_count), 32'd0);

        // Single packet at full rate
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        g0 = get_cyc.size();
        wait_beats(3, 40);
        if (get_cyc.size() >= g0 + 3) begin
            chk("get_spacing_1", 32'(get_cyc[g0+1] - get_cyc[g0]), 32'd3);
            chk("get_spacing_2", 32'(get_cyc[g0+2] - get_cyc[g0+1]), 32'd3);
        end else begin
            chk("get_pulse_count", 32'(get_cyc.size() - g0), 32'd3);
        end
        idle_cycles(2);
        #4;
        chk("busy_after_pkt1", 32'(busy), 32'd0);

        // Zero-length packet: busy only for CAPT and SEND
        @(negedge clk);
        b0 = busy_samples;
        push(3);
        wait_beats(4, 40);
        idle_cycles(3);
        chk("zero_len_busy_cycles", 32'(busy_samples - b0), 32'd2);

        // Header with non-zero upper bits
        @(negedge clk);
        push(4); push(5);
        wait_beats(6, 40);

        // Backpressure on payload word 0xA1
        @(negedge clk);
        push(6); push(7); push(8);
        found = 1'b0;
        for (k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_data == 32'hA1) found = 1'b1;
        end
        out_ready = 1'b0;
        chk("bp_reach_a1", 32'(found), 32'd1);
        d0 = q.size();
        p0 = pop_count;
        g1 = get_cyc.size();
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("bp_hold_data", out_data, 32'hA1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        chk("bp_depth", 32'(q.size()), 32'(d0));
        chk("bp_no_pop", 32'(pop_count), 32'(p0));
        chk("bp_no_get", 32'(get_cyc.size()), 32'(g1));
        out_ready = 1'b1;
        wait_beats(9, 40);

        // Mid-packet underflow: header len 3 with one payload word queued
        @(negedge clk);
        push(9); push(10);
        wait_beats(11, 40);
        idle_cycles(10);
        #4;
        chk("uf_busy_wait", 32'(busy), 32'd1);
        chk("uf_valid_wait", 32'(out_valid), 32'd0);
        chk("uf_beats_wait", 32'(beats.size()), 32'd11);
        @(negedge clk);
        push(11); push(12);
        wait_beats(13, 40);
        idle_cycles(3);
        #4;
        chk("uf_busy_done", 32'(busy), 32'd0);
        n_beats = 13;

`ifdef FIFO_DRAIN_TIMEOUT_EN
        // Stall timeout: header len 3, one payload word, then nothing
        @(negedge clk);
        e0 = err_count;
        push(13); push(14);
        wait_beats(15, 40);
        k = 0;
        while (err_count == e0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        idle_cycles(3);
        #4;
        chk("tmo_err_pulses", 32'(err_count - e0), 32'd1);
        chk("tmo_stall_len", 32'(stall_at_err), 32'(TMO));
        chk("tmo_busy_clear", 32'(busy), 32'd0);
        @(negedge clk);
        push(15);
        wait_beats(16, 40);
        n_beats = 16;
`else
        e0 = 0;
        chk("err_never", 32'(err_count), 32'(e0));
`endif

        // Compare every delivered beat against the table
        for (int i = 0; i < n_beats; i++) begin
            if (i < beats.size()) begin
                chk($sformatf("beat%0d_data", i), beats[i].word, tbl[i].word);
                chk($sformatf("beat%0d_sop", i), 32'(beats[i].sop), 32'(tbl[i].sop));
                chk($sformatf("beat%0d_eop", i), 32'(beats[i].eop), 32'(tbl[i].eop));
            end
        end
        chk("total_beats", 32'(beats.size()), 32'(n_beats));
        chk("fifo_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side master for the router's `fifo_if`. It pops words from a router FIFO using the FIFO's edge-triggered `get` protocol, frames them into packets, and presents them on a valid/ready output stream toward the output port.
- Packet format: one header word whose length field gives N payload words, followed by those N words.
- It is the consumer counterpart of the FIFO's write side.

Parameters:
- DATA_WIDTH, 32, word width; must match the attached FIFO.
- LEN_LSB, 0, bit position of the payload-length field in the header word.
- LEN_W, 8, width of the payload-length field (0..2^LEN_W-1 payload words).
- TIMEOUT_CYC, 1024, stall limit; used only with FIFO_DRAIN_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- fifo_bus  modport  fifo_if.DST
  - drives `get`, holds `put` at 0, leaves `data_in` at 0.
  - samples `empty` and `data_out`; ignores `full`.
- out_data  out  DATA_WIDTH  current word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts word when out_valid && out_ready.
- out_sop  out  1  high with the header word.
- out_eop  out  1  high with the last word of the packet (header too if N=0).
- busy  out  1  high from header pop until eop is accepted.
- err  out  1  one-cycle timeout pulse (only with FIFO_DRAIN_TIMEOUT_EN; otherwise tied 0).

Behaviour:
- Reset (rst=0 at posedge), all outputs:
  - get=0, out_valid=0, out_sop=0, out_eop=0, busy=0, err=0.
  - out_data=0, payload counter=0, state=IDLE.
  - A word popped but not yet delivered is dropped. The FIFO is reset by the same system reset.
- FIFO protocol:
  - The FIFO pops on a rising edge of `get`, detected through its own 1-cycle delay register.
  - `get` is high for exactly one cycle per pop and low in the cycle after.
  - FIFO `data_out` and `empty` are updated at the posedge that ends the get-high cycle.
- FSM states:
  - IDLE: get=0, out_valid=0. If !empty, go to GET.
  - GET: get=1 for one cycle, then go to CAPT.
  - CAPT: get=0. Register data_out into out_data. Go to SEND.
    - If not busy: the word is a header. Set out_sop=1, load counter = header[LEN_LSB+:LEN_W], set busy=1, set out_eop = (len==0).
    - If busy: the word is payload. Set out_sop=0, decrement counter, set out_eop = (counter==1 before decrement).
  - SEND: out_valid=1; out_data, out_sop and out_eop stay stable until accepted.
    - On out_valid && out_ready: if out_eop, clear busy.
    - Then, if !empty, go to GET; else go to IDLE.
- Throughput: 3 cycles/word with out_ready held high and the FIFO non-empty. The get-low cycle in CAPT guarantees the FIFO sees a clean edge each time.
- Empty mid-packet: wait in IDLE with busy=1, indefinitely, unless the timeout feature is compiled in.
- Backpressure: holding out_ready=0 in SEND issues no further gets.
- Length arithmetic: counter is LEN_W bits, unsigned, and never wraps. Decrement happens only when counter>0.
- Headers whose upper bits are non-zero are passed through unchanged; only the length field is interpreted.

Optional Feature:
- Macro: FIFO_DRAIN_TIMEOUT_EN.
- With the macro defined:
  - A stall counter runs while busy=1, state=IDLE and empty=1. It clears on any pop.
  - At TIMEOUT_CYC consecutive stall cycles: err pulses for 1 cycle, busy clears, and the counter resets.
  - The next popped word is treated as a header.
- Without the macro: no stall counter, err is constant 0, and waits are unbounded.

Decomposition:
- router_pkg holds:
  - the drain FSM state enum (IDLE, GET, CAPT, SEND);
  - the LEN_LSB/LEN_W defaults as localparams;
  - a header-length extraction function.
- `fifo_if` gains (or reuses) a DST modport.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: hold rst=0 for 3 clocks with the FIFO holding data -> get=0, out_valid=0, busy=0 throughout; no word lost from the FIFO.
- Single packet: FIFO preloaded with header len=2 (0x00000002), 0xA1, 0xA2, out_ready=1 -> 3 beats.
  - Beat 1: sop=1, data 0x00000002.
  - Beat 2: 0xA1.
  - Beat 3: 0xA2 with eop=1.
  - get pulses spaced 3 cycles apart; busy falls after the last beat.
- Zero-length packet: header 0x00000000 -> one beat with sop=1, eop=1; busy high for exactly the CAPT+SEND cycles.
- Backpressure: out_ready=0 for 10 cycles during payload word 0xA1 -> out_data stays 0xA1, no get pulse, FIFO depth unchanged; resumes correctly when ready returns.
- Mid-packet underflow: header len=3 with only 1 payload word queued -> wait in IDLE with busy=1; after 2 more words are pushed, eop is delivered on the 3rd payload word.
  - With FIFO_DRAIN_TIMEOUT_EN and TIMEOUT_CYC=16 and no push: err pulses after 16 stall cycles, busy=0, and the next word is emitted with sop=1.
